elevator_call_panel: RTL and testbench

Hall-call front end for the 4-floor elevator controller. It synchronises and debounces the four floor call buttons, latches pending calls, and picks one target floor at a time with a SCAN (keep-direction) policy. It drives the target to the controller as the 2-bit code {A,B} with a `req` valid flag. It retires a call when the controller reports the door open at that floor. It is the requesting end of the controller's A/B request interface.

---
 rtl/elevator_call_panel.sv | 167 ++++++++++++++++
 tb/tb_elevator_call_panel.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - hall-call front end: debounce, pending-call lamps, SCAN target select
module elevator_call_panel #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [1:0] floor,
    input  logic       door,
    output logic       A,
    output logic       B,
    output logic       req,
    output logic [3:0] lamp,
    output logic       dir
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE      = 2'd1,
        WAIT_CLOSE = 2'd2
    } state_t;

    // The press is accepted on the edge the counter moves from DEB_CYCLES-1 to DEB_CYCLES,
    // so a continuous hold produces exactly one set pulse.
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    state_t     state;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] cnt [4];
    logic [3:0] set_pulse;
    logic [3:0] clr_mask;
    logic       up_hit;
    logic       dn_hit;
    logic [1:0] up_f;
    logic [1:0] dn_f;
    logic [1:0] lo_any;
    logic [1:0] hi_any;
    logic [1:0] sel_tgt;
    logic       sel_dir;

    // Two-flop synchronisers and saturating debounce counters, one per button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (!sync2[i]) begin
                    cnt[i] <= 4'd0;
                end else if (cnt[i] != 4'hf) begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    // One-edge press acceptance per button
    always_comb begin
        set_pulse = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set_pulse[i] = sync2[i] && (cnt[i] == DEB_LAST);
        end
    end

    // Lamp bit retired on the serving edge; it overrides a simultaneous set
    always_comb begin
        clr_mask = 4'b0000;
        if (state == SERVE && door && floor == {A, B}) begin
            clr_mask = 4'b0001 << {A, B};
        end
    end

    // SCAN candidates: nearest pending floor in each direction plus overall extremes
    always_comb begin
        up_hit = 1'b0;
        up_f   = 2'd0;
        dn_hit = 1'b0;
        dn_f   = 2'd0;
        lo_any = 2'd0;
        hi_any = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (lamp[i]) begin
                lo_any = 2'(i);
                if (2'(i) >= floor) begin
                    up_hit = 1'b1;
                    up_f   = 2'(i);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (lamp[i]) begin
                hi_any = 2'(i);
                if (2'(i) <= floor) begin
                    dn_hit = 1'b1;
                    dn_f   = 2'(i);
                end
            end
        end
    end

    // Keep direction while something lies ahead; otherwise reverse toward the remaining calls
    always_comb begin
        sel_tgt = 2'd0;
        sel_dir = dir;
        if (dir) begin
            if (up_hit) begin
                sel_tgt = up_f;
            end else begin
                sel_tgt = hi_any;
                sel_dir = 1'b0;
            end
        end else begin
            if (dn_hit) begin
                sel_tgt = dn_f;
            end else begin
                sel_tgt = lo_any;
                sel_dir = 1'b1;
            end
        end
    end

    // Request FSM with registered target, valid flag, direction and lamps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            A     <= 1'b0;
            B     <= 1'b0;
            req   <= 1'b0;
            lamp  <= 4'b0000;
            dir   <= 1'b1;
        end else begin
            lamp <= (lamp | set_pulse) & ~clr_mask;
            case (state)
                IDLE: begin
                    if (lamp != 4'b0000) begin
                        {A, B} <= sel_tgt;
                        dir    <= sel_dir;
                        req    <= 1'b1;
                        state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (door && floor == {A, B}) begin
                        req   <= 1'b0;
                        state <= WAIT_CLOSE;
                    end
                end
                WAIT_CLOSE: begin
                    if (!door) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - directed scoreboard bench for elevator_call_panel
`timescale 1ns/1ps
module tb_elevator_call_panel;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] floor;
    logic       door;
    logic       A;
    logic       B;
    logic       req;
    logic [3:0] lamp;
    logic       dir;

    int vectors    = 0;
    int miscompares = 0;

    // expected {dir, target} per request, in order of issue
    logic [2:0] exp_q [$];

    elevator_call_panel #(.DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .floor (floor),
        .door  (door),
        .A     (A),
        .B     (B),
        .req   (req),
        .lamp  (lamp),
        .dir   (dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        tick(DEB + 2);
        btn = 4'b0000;
        tick(3);
    endtask

    task automatic wait_req(input string tag);
        logic [2:0] e;
        for (int k = 0; k < 50 && !req; k++) tick();
        check({tag, "_req"}, {7'd0, req}, 8'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_target"}, {6'd0, A, B}, {6'd0, e[1:0]});
            check({tag, "_dir"}, {7'd0, dir}, {7'd0, e[2]});
        end
    endtask

    task automatic serve(input logic [1:0] f, input string tag);
        floor = f;
        door  = 1'b1;
        tick();
        check({tag, "_req_fall"}, {7'd0, req}, 8'd0);
        check({tag, "_lamp_clr"}, {7'd0, lamp[f]}, 8'd0);
        door = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        btn   = 4'b0000;
        floor = 2'd0;
        door  = 1'b0;
        #12;
        check("rst_ab",   {6'd0, A, B}, 8'd0);
        check("rst_req",  {7'd0, req}, 8'd0);
        check("rst_lamp", {4'd0, lamp}, 8'd0);
        check("rst_dir",  {7'd0, dir}, 8'd1);
        tick();
        reset = 1'b1;
        tick(2);

        // Debounce: a 3-cycle glitch is rejected, the steady press lands 6 edges later
        btn[2] = 1'b1;
        tick(3);
        btn[2] = 1'b0;
        tick();
        btn[2] = 1'b1;
        exp_q.push_back({1'b1, 2'd2});
        tick(DEB + 1);
        check("deb_lamp_early", {4'd0, lamp}, 8'h0);
        tick();
        check("deb_lamp_set", {4'd0, lamp}, 8'h4);
        check("deb_req_low", {7'd0, req}, 8'd0);
        tick();
        check("deb_req_rise", {7'd0, req}, 8'd1);
        wait_req("deb");
        btn = 4'b0000;
        tick(3);

        // Serve handshake with a new call arriving mid-serve
        exp_q.push_back({1'b1, 2'd3});
        press(4'b1000);
        check("hs_lamp", {4'd0, lamp}, 8'hc);
        check("hs_hold_ab", {6'd0, A, B}, 8'd2);
        floor = 2'd1;
        door  = 1'b1;
        tick();
        check("hs_wrong_floor_req", {7'd0, req}, 8'd1);
        check("hs_wrong_floor_lamp", {4'd0, lamp}, 8'hc);
        floor = 2'd2;
        tick();
        check("hs_serve_req", {7'd0, req}, 8'd0);
        check("hs_serve_lamp", {4'd0, lamp}, 8'h8);
        tick(5);
        check("hs_door_held_req", {7'd0, req}, 8'd0);
        door = 1'b0;
        tick();
        check("hs_close_1edge", {7'd0, req}, 8'd0);
        tick();
        check("hs_close_2edge", {7'd0, req}, 8'd1);
        wait_req("hs");

        // No retarget: call at 0 while serving 3
        exp_q.push_back({1'b0, 2'd0});
        press(4'b0001);
        check("nr_lamp", {4'd0, lamp}, 8'h9);
        check("nr_ab", {6'd0, A, B}, 8'd3);
        check("nr_req", {7'd0, req}, 8'd1);
        serve(2'd3, "nr3");
        wait_req("nr");
        serve(2'd0, "nr0");

        // Asynchronous reset mid-serve with calls pending at 1 and 3
        floor = 2'd3;
        press(4'b1010);
        check("ar_lamp", {4'd0, lamp}, 8'ha);
        check("ar_ab", {6'd0, A, B}, 8'd3);
        check("ar_dir", {7'd0, dir}, 8'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_ab0",   {6'd0, A, B}, 8'd0);
        check("ar_req0",  {7'd0, req}, 8'd0);
        check("ar_lamp0", {4'd0, lamp}, 8'h0);
        check("ar_dir1",  {7'd0, dir}, 8'd1);
        exp_q.delete();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ar_idle_req", {7'd0, req}, 8'd0);
        end

        // SCAN from floor 1 going up with 0, 2, 3 pending
        floor = 2'd1;
        exp_q.push_back({1'b1, 2'd2});
        exp_q.push_back({1'b1, 2'd3});
        exp_q.push_back({1'b0, 2'd0});
        btn = 4'b1101;
        tick(DEB + 2);
        check("scan_lamp", {4'd0, lamp}, 8'hd);
        btn = 4'b0000;
        wait_req("scan_a");
        serve(2'd2, "scan2");
        wait_req("scan_b");
        serve(2'd3, "scan3");
        wait_req("scan_c");
        serve(2'd0, "scan0");
        tick(3);
        check("scan_empty_req", {7'd0, req}, 8'd0);

        // Set and clear of lamp[1] on the same edge: clear wins
        exp_q.push_back({1'b1, 2'd1});
        press(4'b0010);
        wait_req("sc");
        btn[1] = 1'b1;
        tick(DEB + 1);
        floor = 2'd1;
        door  = 1'b1;
        tick();
        check("sc_req", {7'd0, req}, 8'd0);
        check("sc_lamp", {4'd0, lamp}, 8'h0);
        btn  = 4'b0000;
        door = 1'b0;
        tick(10);
        check("sc_no_rereq", {7'd0, req}, 8'd0);
        check("sc_lamp_end", {4'd0, lamp}, 8'h0);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
